i_fetch_queue: RTL and testbench

Parametrised instruction-fetch unit with a decoupling instruction queue between memory and decode. It prefetches sequential instructions into a DEPTH-entry FIFO, resolves JAL targets locally, and stalls fetch on conditional branches and JALR until the execute stage returns a PC-relative offset. It sits between the instruction memory port and the decoder, and presents each instruction together with its PC over a valid/ready handshake.

---
 rtl/i_fetch_queue_if.sv | 37 +++
 rtl/i_fetch_queue.sv | 158 +++++++++++++++
 tb/tb_i_fetch_queue.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i_fetch_queue_if.sv
// Signal bundle between i_fetch_queue and its decoder, instruction memory and execute stage.
// flush_valid/flush_pc exist only when IFETCH_FLUSH_EN is defined.
interface i_fetch_queue_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
);
   logic                  inst_valid;
   logic                  inst_ready;
   logic [INST_WIDTH-1:0] inst;
   logic [ADDR_WIDTH-1:0] inst_pc;
   logic                  resolve_valid;
   logic [ADDR_WIDTH-1:0] resolve_offset;
   logic                  mem_valid;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_done;
   logic [INST_WIDTH-1:0] mem_inst;
`ifdef IFETCH_FLUSH_EN
   logic                  flush_valid;
   logic [ADDR_WIDTH-1:0] flush_pc;
`endif

   modport master (
      output inst_valid, inst, inst_pc, mem_valid, mem_addr,
      input  inst_ready, resolve_valid, resolve_offset, mem_done, mem_inst
`ifdef IFETCH_FLUSH_EN
      , input flush_valid, flush_pc
`endif
   );

   modport slave (
      input  inst_valid, inst, inst_pc, mem_valid, mem_addr,
      output inst_ready, resolve_valid, resolve_offset, mem_done, mem_inst
`ifdef IFETCH_FLUSH_EN
      , output flush_valid, flush_pc
`endif
   );
endinterface

// File: rtl/i_fetch_queue.sv
// Instruction fetch unit: sequential prefetch into a DEPTH-entry queue, local JAL redirect,
// stall on branch/JALR until resolved. IFETCH_FLUSH_EN adds a flush port and DRAIN state.
module i_fetch_queue #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input logic             clk,
   input logic             rst,
   i_fetch_queue_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      BR_WAIT
`ifdef IFETCH_FLUSH_EN
      , DRAIN
`endif
   } state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] pc, pc_next;
   logic [ADDR_WIDTH-1:0] br_pc, br_pc_next;
   logic                  mem_valid, mem_valid_next;
   logic                  push, pop, flush;

   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr, wr_ptr;
   logic [CNT_W-1:0]      count;

   logic [6:0]            opcode;
   logic [20:0]           jal_imm;

   assign opcode  = bus.mem_inst[6:0];
   assign jal_imm = {bus.mem_inst[31], bus.mem_inst[19:12], bus.mem_inst[20],
                     bus.mem_inst[30:21], 1'b0};

`ifdef IFETCH_FLUSH_EN
   assign flush = bus.flush_valid;
`else
   assign flush = 1'b0;
`endif

   assign bus.inst_valid = (count != '0);
   assign bus.inst       = inst_mem[rd_ptr];
   assign bus.inst_pc    = pc_mem[rd_ptr];
   assign bus.mem_valid  = mem_valid;
   assign bus.mem_addr   = pc;

   assign pop = bus.inst_valid && bus.inst_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next     = state;
      mem_valid_next = mem_valid;
      pc_next        = pc;
      br_pc_next     = br_pc;
      push           = 1'b0;
      unique case (state)
         IDLE: begin
            if (count < CNT_W'(DEPTH)) begin
               mem_valid_next = 1'b1;
               state_next     = REQ;
            end
         end
         REQ: begin
            if (bus.mem_done) begin
               mem_valid_next = 1'b0;
               push           = 1'b1;
               if (opcode == OP_BRANCH || opcode == OP_JALR) begin
                  br_pc_next = pc;
                  state_next = BR_WAIT;
               end else if (opcode == OP_JAL) begin
                  pc_next    = pc + ADDR_WIDTH'($signed(jal_imm));
                  state_next = IDLE;
               end else begin
                  pc_next    = pc + ADDR_WIDTH'(4);
                  state_next = IDLE;
               end
            end
         end
         BR_WAIT: begin
            if (bus.resolve_valid) begin
               pc_next    = br_pc + bus.resolve_offset;
               state_next = IDLE;
            end
         end
`ifdef IFETCH_FLUSH_EN
         DRAIN: begin
            if (bus.mem_done) begin
               mem_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
`ifdef IFETCH_FLUSH_EN
      // Flush overrides everything; a request still in flight must be drained, not pushed.
      if (bus.flush_valid) begin
         push       = 1'b0;
         pc_next    = bus.flush_pc;
         br_pc_next = br_pc;
         if ((state == REQ || state == DRAIN) && !bus.mem_done) begin
            state_next     = DRAIN;
            mem_valid_next = 1'b1;
         end else begin
            state_next     = IDLE;
            mem_valid_next = 1'b0;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         br_pc     <= '0;
         mem_valid <= 1'b0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
      end else begin
         pc        <= pc_next;
         br_pc     <= br_pc_next;
         mem_valid <= mem_valid_next;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= pc;
         inst_mem[wr_ptr] <= bus.mem_inst;
      end
   end
endmodule

// File: tb/tb_i_fetch_queue.sv
// Bench for i_fetch_queue: directed scenarios plus randomized traffic, every cycle compared
// against a transaction-level model (expected fetch address, expected queue contents).
module tb_i_fetch_queue;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] ADDI  = 32'h0010_0093;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   i_fetch_queue_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus_if ();

   i_fetch_queue #(
      .ADDR_WIDTH(32),
      .INST_WIDTH(32),
      .DEPTH(DEPTH),
      .RESET_PC(32'h0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // model of what the fetch unit must be doing
   ent_t        mq[$];
   bit          m_req, m_wait, m_idle, m_drain;
   logic [31:0] m_pc, m_br;
   int unsigned req_age;
   logic [31:0] req_log[$];
   logic [31:0] prog_mem[logic [31:0]];

   // stimulus knobs
   int unsigned k_ready, k_done, k_resolve, k_rst, k_flush;
   bit          rand_inst, rand_offset, force_resolve, force_flush, do_rst, checking;
   logic [31:0] fix_offset, fix_flush_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] jal_off(input logic [31:0] i);
      int v;
      v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      if (i[31]) v = v - (1 << 20);
      return 32'(v);
   endfunction

   function automatic logic [31:0] rnd_inst();
      logic [31:0] r;
      r = $urandom();
      case ($urandom_range(3))
         0:       return r;
         1:       return {r[31:7], 7'b1100011};
         2:       return {r[31:7], 7'b1100111};
         default: return {r[31:7], 7'b1101111};
      endcase
   endfunction

   task automatic model_reset();
      mq.delete();
      req_log.delete();
      m_req   = 1'b0;
      m_wait  = 1'b0;
      m_idle  = 1'b1;
      m_drain = 1'b0;
      m_pc    = 32'h0;
      m_br    = 32'h0;
      req_age = 0;
   endtask

   // One clock cycle: compare at the falling edge, drive inputs, advance the model.
   task automatic step();
      bit          allowed, done_in, pop, new_req, fl, r_now;
      int unsigned sz;
      logic [31:0] w;
      @(negedge clk);
      if (checking) begin
         chk("mem_valid", 32'(bus_if.mem_valid), 32'(m_req));
         chk("mem_addr", bus_if.mem_addr, m_pc);
         chk("inst_valid", 32'(bus_if.inst_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            chk("inst", bus_if.inst, mq[0].inst);
            chk("inst_pc", bus_if.inst_pc, mq[0].pc);
         end
      end
      allowed = m_req && (req_age >= 1);
      r_now   = do_rst || ($urandom_range(999) < k_rst);
      rst     = r_now;
      bus_if.inst_ready = ($urandom_range(99) < k_ready);
      done_in = allowed && ($urandom_range(99) < k_done);
      bus_if.mem_done = done_in;
      w = rand_inst ? rnd_inst() : (prog_mem.exists(m_pc) ? prog_mem[m_pc] : ADDI);
      bus_if.mem_inst = done_in ? w : $urandom();
      bus_if.resolve_valid  = force_resolve || ($urandom_range(99) < k_resolve);
      bus_if.resolve_offset = rand_offset ? 32'((int'($urandom_range(32)) - 16) * 4) : fix_offset;
`ifdef IFETCH_FLUSH_EN
      bus_if.flush_valid = force_flush || ($urandom_range(99) < k_flush);
      bus_if.flush_pc    = force_flush ? fix_flush_pc : {22'h0, 8'($urandom_range(255)), 2'b00};
`endif
      new_req = 1'b0;
      fl      = 1'b0;
      if (r_now) begin
         model_reset();
      end else begin
         sz  = mq.size();
         pop = (sz != 0) && bus_if.inst_ready;
`ifdef IFETCH_FLUSH_EN
         if (bus_if.flush_valid) begin
            fl = 1'b1;
            mq.delete();
            m_pc   = bus_if.flush_pc;
            m_wait = 1'b0;
            if (m_req && !done_in) m_drain = 1'b1;
            else begin
               m_req   = 1'b0;
               m_drain = 1'b0;
               m_idle  = 1'b1;
            end
         end
`endif
         if (!fl) begin
            if (m_drain) begin
               if (done_in) begin
                  m_req   = 1'b0;
                  m_drain = 1'b0;
                  m_idle  = 1'b1;
               end
            end else if (done_in) begin
               mq.push_back('{m_pc, w});
               m_req = 1'b0;
               if (w[6:0] == 7'b1100011 || w[6:0] == 7'b1100111) begin
                  m_wait = 1'b1;
                  m_br   = m_pc;
               end else if (w[6:0] == 7'b1101111) begin
                  m_pc   = m_pc + jal_off(w);
                  m_idle = 1'b1;
               end else begin
                  m_pc   = m_pc + 32'd4;
                  m_idle = 1'b1;
               end
            end else if (m_idle) begin
               if (sz < DEPTH) begin
                  m_req   = 1'b1;
                  m_idle  = 1'b0;
                  new_req = 1'b1;
                  req_log.push_back(m_pc);
               end
            end else if (m_wait && bus_if.resolve_valid) begin
               m_pc   = m_br + bus_if.resolve_offset;
               m_wait = 1'b0;
               m_idle = 1'b1;
            end
            if (pop) void'(mq.pop_front());
         end
      end
      if (new_req) req_age = 0;
      else if (m_req) req_age++;
   endtask

   task automatic do_reset();
      do_rst = 1'b1;
      step();
      do_rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
      $fatal(1);
   end

   initial begin
      int unsigned n_hi, lsz;
      bus_if.inst_ready     = 1'b0;
      bus_if.mem_done       = 1'b0;
      bus_if.mem_inst       = '0;
      bus_if.resolve_valid  = 1'b0;
      bus_if.resolve_offset = '0;
`ifdef IFETCH_FLUSH_EN
      bus_if.flush_valid = 1'b0;
      bus_if.flush_pc    = '0;
`endif
      k_ready = 0; k_done = 100; k_resolve = 0; k_rst = 0; k_flush = 0;
      rand_inst = 0; rand_offset = 0; force_resolve = 0; force_flush = 0;
      fix_offset = 32'h4; fix_flush_pc = 32'h0;
      checking = 0;
      model_reset();
      do_reset();
      do_reset();
      checking = 1;

      // sequential fill with decoder stalled
      repeat (20) step();
      chk("fill req count", req_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("fill req addr", req_log[i], 32'(i * 4));
      chk("full no fetch", 32'(bus_if.mem_valid), 32'h0);
      chk("full head pc", bus_if.inst_pc, 32'h0);
      chk("full head inst", bus_if.inst, ADDI);

      // single pop from a full queue: fetch 2 cycles later at 16
      k_ready = 100;
      step();
      k_ready = 0;
      step();
      chk("pop N+1 mem_valid", 32'(bus_if.mem_valid), 32'h0);
      step();
      chk("pop N+2 mem_valid", 32'(bus_if.mem_valid), 32'h1);
      chk("pop N+2 mem_addr", bus_if.mem_addr, 32'h10);

      // bne at 0x8, resolved back to 0 after 5 cycles
      do_reset();
      prog_mem.delete();
      prog_mem[32'h8] = 32'h0000_1463;
      k_ready = 100; k_done = 100; k_resolve = 0; fix_offset = 32'hFFFF_FFF8;
      for (int i = 0; i < 50 && !m_wait; i++) step();
      chk("branch reached", 32'(m_wait), 32'h1);
      n_hi = 0;
      repeat (5) begin
         step();
         if (bus_if.mem_valid) n_hi++;
      end
      chk("no fetch in branch wait", n_hi, 0);
      force_resolve = 1;
      step();
      force_resolve = 0;
      step();
      chk("resolve R+1 mem_valid", 32'(bus_if.mem_valid), 32'h0);
      step();
      chk("resolve R+2 mem_valid", 32'(bus_if.mem_valid), 32'h1);
      chk("resolve target", bus_if.mem_addr, 32'h0);

      // jal x0,+0x100 at 0x10 while resolve_valid toggles randomly
      do_reset();
      prog_mem.delete();
      prog_mem[32'h10] = 32'h1000_006F;
      k_resolve = 50; rand_offset = 1;
      for (int i = 0; i < 60 && req_log.size() < 6; i++) step();
      chk("jal req count", 32'(req_log.size() >= 6), 32'h1);
      chk("jal source addr", req_log[4], 32'h10);
      chk("jal target addr", req_log[5], 32'h110);

      // randomized traffic, including push/pop overlap, wrap and mid-run resets
      rand_inst = 1; k_done = 60; k_resolve = 25; k_rst = 2;
`ifdef IFETCH_FLUSH_EN
      k_flush = 3;
`endif
      k_ready = 50; repeat (3000) step();
      k_ready = 90; repeat (2000) step();
      k_ready = 15; repeat (2000) step();
      k_rst = 0; k_flush = 0;

`ifdef IFETCH_FLUSH_EN
      // flush mid-request: queue empties at once, late word dropped, restart at 0x200
      rand_inst = 0; prog_mem.delete(); k_resolve = 0;
      do_reset();
      k_ready = 0; k_done = 100;
      for (int i = 0; i < 30 && mq.size() < 2; i++) step();
      k_done = 0;
      for (int i = 0; i < 10 && !m_req; i++) step();
      step();
      force_flush = 1; fix_flush_pc = 32'h200;
      step();
      force_flush = 0;
      step();
      chk("flush queue empty", 32'(bus_if.inst_valid), 32'h0);
      chk("flush drain mem_valid", 32'(bus_if.mem_valid), 32'h1);
      lsz = req_log.size();
      k_done = 100;
      step();
      step();
      chk("flush late word dropped", 32'(bus_if.inst_valid), 32'h0);
      for (int i = 0; i < 10 && req_log.size() == lsz; i++) step();
      chk("flush restart addr", req_log[req_log.size() - 1], 32'h200);
      step();
      chk("flush restart mem_addr", bus_if.mem_addr, 32'h200);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
